// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and types for the SPI master/slave blocks.
package spi_pkg;

  // Default word length shared by master and slave.
  localparam int SPI_DATA_WIDTH = 8;

  // Depth of the input synchronizer on the asynchronous SPI pins.
  localparam int SPI_SYNC_STAGES = 2;

  // Responder frame state: waiting for chip select, or inside a frame.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_slave_state_t;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: N-stage flop synchronizer for a bundle of asynchronous inputs.
module spi_sync #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_stage [STAGES];

  // Capture the raw pins, then walk them down the chain to settle metastability.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= RST_VAL;
      end
    end else begin
      r_stage[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q_o = r_stage[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampling SPI responder, all four CPOL/CPHA modes, MSB first,
// with a one-entry valid/ready buffer on both the tx and rx sides.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  sclk_i,
  input  logic                  cs_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic                  underrun_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchronized pins, ordered {sclk, cs_n, mosi}; cs_n idles high.
  logic [2:0] w_sync;
  logic       w_sclk_s, w_cs_n_s, w_mosi_s;

  spi_sync #(
    .WIDTH  (3),
    .STAGES (SPI_SYNC_STAGES),
    .RST_VAL(3'b010)
  ) u_sync (
    .clk_i  (clk_i),
    .arstn_i(arstn_i),
    .d_i    ({sclk_i, cs_n_i, mosi_i}),
    .q_o    (w_sync)
  );

  assign {w_sclk_s, w_cs_n_s, w_mosi_s} = w_sync;

  spi_slave_state_t        r_state;
  logic                    r_sclk_d, r_cs_n_d;
  logic                    r_cpol, r_cpha;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-2:0]   r_rx_shift;
  logic [DATA_WIDTH-1:0]   r_tx_shift;
  logic                    r_load_pending;
  logic                    r_miso_oe, r_busy;
  logic [DATA_WIDTH-1:0]   r_tx_buf;
  logic                    r_tx_ready, r_underrun;
  logic [DATA_WIDTH-1:0]   r_rx_data;
  logic                    r_rx_valid, r_overflow;

  // History flops for edge detection on the synchronized clock and select.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_sclk_d <= 1'b0;
      r_cs_n_d <= 1'b1;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_cs_n_d <= w_cs_n_s;
    end
  end

  logic w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall, w_lead, w_trail;
  logic w_active, w_shift, w_sample, w_word_done;
  logic w_load, w_load_start, w_load_run;
  logic [DATA_WIDTH-1:0] w_load_word, w_rx_word;

  assign w_cs_fall   = r_cs_n_d & ~w_cs_n_s;
  assign w_cs_rise   = ~r_cs_n_d & w_cs_n_s;
  assign w_sclk_rise = ~r_sclk_d & w_sclk_s;
  assign w_sclk_fall = r_sclk_d & ~w_sclk_s;
  // Leading edge moves SCLK away from its idle level, trailing edge returns it.
  assign w_lead      = r_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = r_cpol ? w_sclk_rise : w_sclk_fall;

  // Edges are ignored in the cycle the frame ends so an abort wins over data.
  assign w_active    = (r_state == ACTIVE) && !w_cs_rise;
  assign w_shift     = w_active && (r_cpha ? w_lead : w_trail);
  assign w_sample    = w_active && (r_cpha ? w_trail : w_lead);
  assign w_word_done = w_sample && (r_bit_cnt == CNT_LAST);
  assign w_rx_word   = {r_rx_shift, w_mosi_s};

  // CPHA=0 preloads at select; afterwards a load replaces a shift at word boundaries.
  assign w_load_start = (r_state == IDLE) && w_cs_fall && !cpha_i;
  assign w_load_run   = w_shift && (r_cpha ? r_load_pending : (r_bit_cnt == CNT_FULL));
  assign w_load       = w_load_start || w_load_run;
  // An empty buffer (ready high) feeds zeros into the shifter.
  assign w_load_word  = r_tx_ready ? '0 : r_tx_buf;

  // Frame FSM: mode latch, bit counting and both shift registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state        <= IDLE;
      r_cpol         <= 1'b0;
      r_cpha         <= 1'b0;
      r_bit_cnt      <= '0;
      r_rx_shift     <= '0;
      r_tx_shift     <= '0;
      r_load_pending <= 1'b0;
      r_miso_oe      <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state    <= ACTIVE;
            r_cpol     <= cpol_i;
            r_cpha     <= cpha_i;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_miso_oe  <= 1'b1;
            r_busy     <= 1'b1;
            if (cpha_i) begin
              r_load_pending <= 1'b1;
            end else begin
              r_tx_shift <= w_load_word;
            end
          end
        end
        ACTIVE: begin
          if (w_cs_rise) begin
            // Partial words are discarded; a preloaded tx word is simply lost.
            r_state        <= IDLE;
            r_bit_cnt      <= '0;
            r_rx_shift     <= '0;
            r_load_pending <= 1'b0;
            r_miso_oe      <= 1'b0;
            r_busy         <= 1'b0;
          end else begin
            if (w_sample) begin
              r_rx_shift <= w_rx_word[DATA_WIDTH-2:0];
              if (!w_word_done) begin
                r_bit_cnt <= r_bit_cnt + CNT_ONE;
              end else if (r_cpha) begin
                r_bit_cnt      <= '0;
                r_load_pending <= 1'b1;
              end else begin
                // Held at full until the following trailing edge reloads.
                r_bit_cnt <= CNT_FULL;
              end
            end
            if (w_shift) begin
              if (w_load) begin
                r_tx_shift     <= w_load_word;
                r_load_pending <= 1'b0;
                if (!r_cpha) begin
                  r_bit_cnt <= '0;
                end
              end else begin
                r_tx_shift <= r_tx_shift << 1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tx holding buffer; a same-cycle load sees the pre-capture contents.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_tx_buf   <= '0;
      r_tx_ready <= 1'b1;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_load && r_tx_ready;
      if (tx_valid_i && r_tx_ready) begin
        r_tx_buf   <= tx_data_i;
        r_tx_ready <= 1'b0;
      end else if (w_load && !r_tx_ready) begin
        r_tx_ready <= 1'b1;
      end
    end
  end

  // Rx holding register: accept a finished word unless an unread one blocks it.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (w_word_done) begin
        if (!r_rx_valid || rx_ready_i) begin
          r_rx_data  <= w_rx_word;
          r_rx_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (rx_ready_i) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign miso_o     = r_tx_shift[DATA_WIDTH-1];
  assign miso_oe_o  = r_miso_oe;
  assign busy_o     = r_busy;
  assign tx_ready_o = r_tx_ready;
  assign underrun_o = r_underrun;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: bit-banged SPI master driving spi_slave, checked against a
// word-level model of what each side should receive.
module tb_spi_slave;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic          miso, miso_oe, tx_ready, rx_valid, busy, overflow, underrun;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(DW)) dut (
    .clk_i     (clk),
    .arstn_i   (arstn),
    .cpol_i    (cpol),
    .cpha_i    (cpha),
    .sclk_i    (sclk),
    .cs_n_i    (cs_n),
    .mosi_i    (mosi),
    .miso_o    (miso),
    .miso_oe_o (miso_oe),
    .tx_data_i (tx_data),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .rx_ready_i(rx_ready),
    .busy_o    (busy),
    .overflow_o(overflow),
    .underrun_o(underrun)
  );

  // Model state: words offered to the slave, words the slave must report,
  // and the pulse counts the rules predict.
  logic [DW-1:0] feed_q[$];
  logic [DW-1:0] m_txq[$];
  logic [DW-1:0] rx_exp_q[$];
  logic [DW-1:0] send_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_master[$];
  int ovf_exp = 0, ovf_seen = 0, und_exp = 0, und_seen = 0;
  int hs_count = 0;
  logic [DW-1:0] last_rx = '0;
  bit mon_en = 1'b1;
  logic cs_seen = 1'b1;
  int cs_stable = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Tx feeder: offer queued words whenever the slave buffer is empty.
  initial begin
    forever begin
      @(posedge clk);
      if (arstn && tx_valid && tx_ready && feed_q.size() > 0) void'(feed_q.pop_front());
      @(negedge clk);
      if (feed_q.size() > 0) begin
        tx_valid = 1'b1;
        tx_data  = feed_q[0];
      end else begin
        tx_valid = 1'b0;
      end
    end
  end

  // Rx consumer: every handshake retires the oldest expected word.
  always @(posedge clk) begin
    if (arstn && mon_en && rx_valid && rx_ready) begin
      hs_count++;
      last_rx = rx_data;
      $display("rx handshake: word=0x%0h", rx_data);
      if (rx_exp_q.size() > 0) void'(rx_exp_q.pop_front());
    end
  end

  // Per-cycle compare against the model.
  always begin
    @(posedge clk);
    #1;
    if (mon_en && arstn) begin
      if (overflow) ovf_seen++;
      if (underrun) und_seen++;
      if (cs_n == cs_seen) cs_stable++;
      else begin
        cs_stable = 0;
        cs_seen   = cs_n;
      end
      if (cs_stable >= 4) begin
        check("miso_oe_vs_cs", miso_oe, !cs_n);
        check("busy_vs_cs", busy, !cs_n);
      end
      if (rx_valid) begin
        if (rx_exp_q.size() == 0) check("rx_valid_unexpected", rx_valid, 1'b0);
        else check("rx_data", rx_data, rx_exp_q[0]);
      end
    end
  end

  task automatic offer(input logic [DW-1:0] w);
    feed_q.push_back(w);
    m_txq.push_back(w);
  endtask

  // A word finished at the master: accepted unless an unread one is blocking.
  task automatic model_rx(input logic [DW-1:0] w);
    if (rx_exp_q.size() > 0 && !rx_ready) ovf_exp++;
    else rx_exp_q.push_back(w);
  endtask

  // One frame of nbits from send_q in the given mode, half-period h cycles.
  task automatic run_frame(input bit pol, input bit pha, input int h, input int nbits);
    int nfull, nstart, nloads;
    logic [DW-1:0] w, acc;
    logic tbit;
    exp_master.delete();
    got_q.delete();
    nfull  = nbits / DW;
    nstart = (nbits + DW - 1) / DW;
    // CPHA=1 loads as each word starts; CPHA=0 loads at select and after each word.
    nloads = pha ? nstart : nfull + 1;
    for (int k = 0; k < nloads; k++) begin
      if (m_txq.size() > 0) exp_master.push_back(m_txq.pop_front());
      else begin
        exp_master.push_back('0);
        und_exp++;
      end
    end
    @(negedge clk);
    cpol = pol; cpha = pha; sclk = pol; mosi = 1'b0;
    repeat (6) @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    cpol = 1'($urandom);
    cpha = 1'($urandom);
    acc = '0;
    for (int b = 0; b < nbits; b++) begin
      w    = send_q[b / DW];
      tbit = w[DW-1-(b % DW)];
      if (!pha) begin
        mosi = tbit;
        repeat (h) @(negedge clk);
        sclk = ~pol;
        acc  = {acc[DW-2:0], miso};
        if (b % DW == DW - 1) begin
          got_q.push_back(acc);
          model_rx(w);
        end
        repeat (h) @(negedge clk);
        sclk = pol;
      end else begin
        sclk = ~pol;
        mosi = tbit;
        repeat (h) @(negedge clk);
        sclk = pol;
        acc  = {acc[DW-2:0], miso};
        if (b % DW == DW - 1) begin
          got_q.push_back(acc);
          model_rx(w);
        end
        repeat (h) @(negedge clk);
      end
    end
    repeat (h) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    for (int k = 0; k < nfull; k++) begin
      $display("frame mode=%0d word %0d: master sent=0x%0h got=0x%0h want=0x%0h",
               {pol, pha}, k, send_q[k], got_q[k], exp_master[k]);
      check("master_word", got_q[k], exp_master[k]);
    end
    check("overflow_count", ovf_seen, ovf_exp);
    check("underrun_count", und_seen, und_exp);
    if (rx_ready) check("rx_pending", rx_exp_q.size(), 0);
  endtask

  int hs0, ovf0, und0;
  logic [DW-1:0] rw;
  int nw, np, hh;
  bit rp, rh;

  initial begin
    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    #1;
    check("rst_miso", miso, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_data", rx_data, '0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    @(negedge clk);
    arstn = 1'b1;
    repeat (5) @(negedge clk);

    // Mode 0 basic.
    hs0 = hs_count;
    offer(8'hA5);
    send_q = '{8'h3C};
    run_frame(1'b0, 1'b0, 4, DW);
    check("basic_master_A5", got_q[0], 8'hA5);
    check("basic_rx_3C", last_rx, 8'h3C);
    check("basic_one_valid", hs_count - hs0, 1);

    // All four modes.
    for (int m = 0; m < 4; m++) begin
      offer(8'h7E);
      send_q = '{8'h81};
      run_frame(m[1], m[0], 4, DW);
      check("modes_master_7E", got_q[0], 8'h7E);
      check("modes_rx_81", last_rx, 8'h81);
    end

    // Burst of three words in one CPHA=1 frame.
    und0 = und_seen;
    offer(8'h11); offer(8'h22); offer(8'h33);
    send_q = '{8'h5A, 8'hC0, 8'h0F};
    run_frame(1'b0, 1'b1, 4, 3 * DW);
    check("burst_w0", got_q[0], 8'h11);
    check("burst_w1", got_q[1], 8'h22);
    check("burst_w2", got_q[2], 8'h33);
    check("burst_no_underrun", und_seen - und0, 0);
    check("burst_rx_last", last_rx, 8'h0F);

    // Backpressure: two words with the consumer stalled.
    ovf0 = ovf_seen;
    rx_ready = 1'b0;
    offer(8'hE1); offer(8'hE2);
    send_q = '{8'h01, 8'h02};
    run_frame(1'b0, 1'b1, 4, 2 * DW);
    check("bp_rx_data_held", rx_data, 8'h01);
    check("bp_rx_valid_held", rx_valid, 1'b1);
    check("bp_one_overflow", ovf_seen - ovf0, 1);
    @(negedge clk);
    rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("bp_drained", rx_exp_q.size(), 0);
    check("bp_consumed_01", last_rx, 8'h01);

    // Empty tx buffer in mode 3.
    und0 = und_seen;
    send_q = '{8'h99};
    run_frame(1'b1, 1'b1, 4, DW);
    check("empty_master_00", got_q[0], 8'h00);
    check("empty_one_underrun", und_seen - und0, 1);

    // Abort after five bits, then a clean word.
    hs0 = hs_count;
    offer(8'h5A);
    send_q = '{8'hFF};
    run_frame(1'b1, 1'b0, 4, 5);
    check("abort_no_valid", hs_count - hs0, 0);
    offer(8'h3E);
    send_q = '{8'hC3};
    run_frame(1'b1, 1'b0, 4, DW);
    check("abort_next_rx_C3", last_rx, 8'hC3);
    check("abort_next_master", got_q[0], 8'h3E);

    // Randomized frames.
    for (int i = 0; i < 12; i++) begin
      rp = 1'($urandom);
      rh = 1'($urandom);
      nw = $urandom_range(1, 3);
      hh = $urandom_range(4, 6);
      send_q.delete();
      for (int k = 0; k < nw; k++) begin
        rw = DW'($urandom);
        send_q.push_back(rw);
      end
      np = $urandom_range(0, rh ? nw : nw + 1);
      for (int k = 0; k < np; k++) begin
        rw = DW'($urandom);
        offer(rw);
      end
      run_frame(rp, rh, hh, nw * DW);
    end

    // Reset in the middle of a frame.
    mon_en = 1'b0;
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
    feed_q.push_back(8'hAA);
    feed_q.push_back(8'h55);
    repeat (6) @(negedge clk);
    cs_n = 1'b0;
    repeat (10) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      mosi = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    arstn = 1'b0;
    #1;
    check("mid_rst_miso", miso, 1'b0);
    check("mid_rst_miso_oe", miso_oe, 1'b0);
    check("mid_rst_tx_ready", tx_ready, 1'b1);
    check("mid_rst_rx_data", rx_data, '0);
    check("mid_rst_rx_valid", rx_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_underrun", underrun, 1'b0);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    errors++;
    checks++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder: the far end of the team's SPI master, used where our FPGA is itself a peripheral on an external SPI bus. It oversamples SCLK/CS_N/MOSI on the system clock and shifts `DATA_WIDTH`-bit words MSB-first in all four CPOL/CPHA modes. Words go in and out through a one-entry valid/ready buffer in each direction, so it can feed a FIFO or register file directly.

## Interface
- `DATA_WIDTH`, default `spi_pkg::SPI_DATA_WIDTH` (8): word length in bits, 2..32.
- `clk_i` input 1: system clock; must be at least 8× the SCLK frequency.
- `arstn_i` input 1: reset, asynchronous, active-low.
- `cpol_i` input 1: clock polarity; latched at CS_N assertion.
- `cpha_i` input 1: clock phase; latched at CS_N assertion.
- `sclk_i` input 1: SPI clock from master (asynchronous).
- `cs_n_i` input 1: chip select, active-low (asynchronous).
- `mosi_i` input 1: serial data in (asynchronous).
- `miso_o` output 1: serial data out.
- `miso_oe_o` output 1: MISO output enable; high only while selected.
- `tx_data_i` input DATA_WIDTH: next word to send.
- `tx_valid_i` input 1: tx word offered.
- `tx_ready_o` output 1: tx buffer empty.
- `rx_data_o` output DATA_WIDTH: last received word.
- `rx_valid_o` output 1: rx word held.
- `rx_ready_i` input 1: rx word consumed.
- `busy_o` output 1: frame in progress (synchronized CS_N low).
- `overflow_o` output 1: one-cycle pulse; received word dropped.
- `underrun_o` output 1: one-cycle pulse; tx buffer empty at a word load, zeros sent.

## Operation
- Reset values: `miso_o`=0, `miso_oe_o`=0, `tx_ready_o`=1, `rx_data_o`=0, `rx_valid_o`=0, `busy_o`=0, `overflow_o`=0, `underrun_o`=0. The shift registers, bit counter and latched mode are 0, and the FSM starts in IDLE.
- **Input synchronization:** `sclk_i`, `cs_n_i` and `mosi_i` each pass through a 2-flop synchronizer, then one history flop for edge detection.
- **Edge naming:** leading edge is the SCLK transition away from CPOL; trailing edge is the transition back to CPOL.
- **FSM states:**
  - IDLE → ACTIVE on synchronized CS_N falling.
  - ACTIVE → IDLE on synchronized CS_N rising.
  - No other transitions.
- **Entering ACTIVE:**
  - Latch `cpol_i`/`cpha_i`; clear the bit counter; assert `miso_oe_o` and `busy_o`.
  - CPHA=0: load `tx_shift` immediately, so the MSB is on `miso_o` before the first edge.
  - CPHA=1: set the load-pending flag instead.
- **CPHA=0:**
  - Sample MOSI on the leading edge.
  - On the trailing edge, shift `tx_shift` left. If the counter has just reached `DATA_WIDTH`, load the next word instead and clear the counter.
- **CPHA=1:**
  - On the leading edge, shift `tx_shift` left, or load it if load-pending is set, then clear the flag.
  - Sample MOSI on the trailing edge. When the counter reaches `DATA_WIDTH`, clear it and set load-pending.
- **Word load:**
  - If the tx buffer is full, take its word and set `tx_ready_o`=1.
  - Otherwise load 0 and pulse `underrun_o`.
- **tx buffer:** `tx_valid_i && tx_ready_o` captures `tx_data_i` and clears `tx_ready_o`. A load and a capture may occur in the same cycle; the load takes the old word and the buffer stays full.
- **Rx word complete:** on the DATA_WIDTH-th sample:
  - If `rx_valid_o`=0 or `rx_ready_i`=1, the word goes to `rx_data_o` and `rx_valid_o`=1.
  - Otherwise the word is dropped, `overflow_o` pulses, and the held word is kept.
  - `rx_valid_o` clears on `rx_ready_i` when no new word arrives that cycle.
- **Mid-frame config:** changes on `cpol_i`/`cpha_i` are ignored until the next frame.
- **CS_N deassert mid-word:** partial rx bits are discarded with no `rx_valid_o`, the counter clears, and `miso_oe_o`/`busy_o` drop. A word already loaded from the tx buffer is lost and is not re-queued.
- **Reset mid-frame:** all state returns to reset values immediately.

## Timing
- A pin edge is visible to the edge detector 2–3 `clk_i` cycles later (synchronizer plus asynchronous phase).
- **Rx latency:** `rx_valid_o` rises 4 (±1) cycles after the final sampling edge at the pin.
- **`miso_o` latency:** `miso_o` changes 4 (±1) cycles after the shifting edge. This bounds the SCLK half-period to at least 4 `clk_i` cycles, i.e. SCLK ≤ `clk_i`/8.
- **CS_N setup:** the first SCLK edge must follow CS_N falling by at least 4 cycles for CPHA=0 MSB setup.
- All outputs are registered.

## Structure
- **Added to `spi_pkg`:** typedef `spi_slave_state_t` (IDLE, ACTIVE) and constant `SPI_SYNC_STAGES = 2`.
- **Sub-module `spi_sync`:** parameterized-width N-stage synchronizer, instantiated once for {sclk, cs_n, mosi}.

## Test plan
- **Mode 0 basic:**
  - Stimulus: tx=0xA5, master sends 0x3C at `clk_i`/8.
  - Required: master receives 0xA5; `rx_data_o`=0x3C with a single `rx_valid_o`; `miso_oe_o` high only while CS_N is low.
- **All four modes:** master sends 0x81 with tx=0x7E in each mode → both sides receive correctly.
- **Burst of 3 words in one frame:** tx offered 0x11/0x22/0x33 just in time → master gets 0x11 0x22 0x33, no `underrun_o`.
- **Backpressure:** hold `rx_ready_i`=0 across two received words 0x01, 0x02 → `rx_data_o` stays 0x01 and `overflow_o` pulses once.
- **Empty tx buffer:** frame with the tx buffer empty → `miso_o` shifts 0x00 and `underrun_o` pulses once.
- **Abort:** CS_N rises after 5 bits, then a fresh frame of 0xC3 → no `rx_valid_o` for the partial word; the next word is received as 0xC3. Also assert `arstn_i` mid-frame → outputs return to reset values.
